thermo_spi_scanner: RTL and testbench

- Multi-channel successor to the single-sensor thermocouple reader: polls N_CH MAX6675-class SPI temperature converters over one shared SO/SCK bus, each with its own chip select.
- Generates SCK from the system clock with an enable-tick divider; no derived clocks.
- Per frame: extracts the temperature field, applies a signed calibration offset with saturation, flags open-thermocouple, and emits a one-cycle valid strobe tagged with the channel index.
- Sits between the sensor pins and the display/control logic.

---
 rtl/thermo_pkg.sv | 29 ++
 rtl/thermo_spi_scanner_if.sv | 13 +
 rtl/spi_tick_gen.sv | 39 +++
 rtl/thermo_spi_scanner.sv | 140 ++++++++++++++
 tb/tb_thermo_spi_scanner.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/thermo_pkg.sv
// Shared types and helpers for the multi-channel thermocouple SPI scanner.
package thermo_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Offset the raw reading and clamp the sum into [0, 2^out_w-1].
  function automatic int sat_add(input int raw, input int offset, input int out_w);
    int sum;
    int max_v;
    int res;
    sum   = raw + offset;
    max_v = (1 << out_w) - 1;
    if (sum < 0)           res = 0;
    else if (sum > max_v)  res = max_v;
    else                   res = sum;
    return res;
  endfunction

endpackage

// File: rtl/thermo_spi_scanner_if.sv
// Shared sensor bus: one SCK/SO pair and a chip select per sensor.
interface thermo_spi_scanner_if #(
  parameter int N_CH = 4
);
  logic            sck;
  logic [N_CH-1:0] cs_n;
  logic            so;

  // Master drives sck/cs_n, sensors answer on so. No flow control: so is
  // valid from cs_n falling and changes only on sck falling edges.
  modport master (output sck, output cs_n, input so);
  modport slave  (input sck, input cs_n, output so);
endinterface

// File: rtl/spi_tick_gen.sv
// SCK generator: half-period counter with rise/fall tick pulses, idle low when disabled.
module spi_tick_gen #(
  parameter int CLK_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sck_o
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             sck_q;
  logic             at_last;

  assign at_last = en_i && (div_q == LAST);
  assign rise_o  = at_last && !sck_q;
  assign fall_o  = at_last && sck_q;
  assign sck_o   = sck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (at_last) begin
      div_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/thermo_spi_scanner.sv
// Round-robin poller for N_CH MAX6675-class sensors on a shared SPI bus,
// producing calibrated, saturated readings tagged with their channel.
module thermo_spi_scanner
  import thermo_pkg::*;
#(
  parameter int CLK_DIV    = 25000,
  parameter int N_CH       = 4,
  parameter int FRAME_BITS = 16,
  parameter int TEMP_MSB   = 14,
  parameter int TEMP_LSB   = 3,
  parameter int OPEN_BIT   = 2,
  parameter int OUT_W      = 12,
  parameter int CAL_OFFSET = -20,
  parameter int CONV_WAIT  = 11000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  thermo_spi_scanner_if.master      spi,
  output logic [OUT_W-1:0]          temp,
  output logic [ch_width(N_CH)-1:0] temp_ch,
  output logic                      open_tc,
  output logic                      temp_valid,
  output state_e                    dbg_state_o
);
  localparam int CH_W    = ch_width(N_CH);
  localparam int CNT_MAX = (CONV_WAIT > CLK_DIV) ? CONV_WAIT : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CONV_WAIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic [CH_W-1:0]       ptr_q;
  logic [N_CH-1:0]       cs_n_q;
  logic [FRAME_BITS-1:0] sh_q;
  logic [OUT_W-1:0]      temp_q;
  logic [CH_W-1:0]       ch_q;
  logic                  open_q;
  logic                  valid_q;
  logic [OUT_W-1:0]      temp_d;
  logic                  rise;
  logic                  fall;
  logic                  sck_w;
  logic                  unused_frame;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == S_SHIFT),
    .rise_o (rise),
    .fall_o (fall),
    .sck_o  (sck_w)
  );

  assign temp_d = OUT_W'(sat_add(int'(sh_q[TEMP_MSB:TEMP_LSB]), CAL_OFFSET, OUT_W));
  assign unused_frame = ^sh_q;

  // The wait counter stops at 1 so WAIT lasts exactly CONV_WAIT cycles
  // when enable is already high; with enable low it parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      cnt_q   <= WAIT_LOAD;
      bit_q   <= '0;
      ptr_q   <= '0;
      cs_n_q  <= '1;
      sh_q    <= '0;
      temp_q  <= '0;
      ch_q    <= '0;
      open_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            cnt_q <= '0;
            if (enable) begin
              state_q <= S_SETUP;
              cnt_q   <= HALF_LOAD;
              cs_n_q  <= ~(N_CH'(1) << ptr_q);
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_SHIFT;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (rise) sh_q <= {sh_q[FRAME_BITS-2:0], spi.so};
          if (fall) begin
            bit_q <= bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
              state_q <= S_HOLD;
              cnt_q   <= HALF_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            cs_n_q  <= '1;
            valid_q <= 1'b1;
            ch_q    <= ptr_q;
            open_q  <= sh_q[OPEN_BIT];
            temp_q  <= sh_q[OPEN_BIT] ? '0 : temp_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_WAIT;
          cnt_q   <= WAIT_LOAD;
          ptr_q   <= (ptr_q == LAST_CH) ? '0 : ptr_q + CH_W'(1);
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign spi.sck     = sck_w;
  assign spi.cs_n    = cs_n_q;
  assign temp        = temp_q;
  assign temp_ch     = ch_q;
  assign open_tc     = open_q;
  assign temp_valid  = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_thermo_spi_scanner.sv
// Bench for thermo_spi_scanner: three instances (offset 0 / -20 / +20) driven by sensor models.
module tb_thermo_spi_scanner;
  import thermo_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int CONV_WAIT = 10;
  localparam int FRAME_CYC = CLK_DIV * (2 * 16 + 2);
  localparam int PERIOD    = FRAME_CYC + CONV_WAIT + 1;
  localparam int TIMEOUT   = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_a_n;
  logic en_a, en_b, en_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- DUTs ----------------
  thermo_spi_scanner_if #(.N_CH(3)) spi_a ();
  thermo_spi_scanner_if #(.N_CH(1)) spi_b ();
  thermo_spi_scanner_if #(.N_CH(1)) spi_c ();

  logic [11:0] temp_a, temp_b, temp_c;
  logic [1:0]  ch_a;
  logic        ch_b, ch_c;
  logic        open_a, open_b, open_c;
  logic        valid_a, valid_b, valid_c;
  state_e      dbg_a, dbg_b, dbg_c;

  thermo_spi_scanner #(.CLK_DIV(CLK_DIV), .N_CH(3), .CAL_OFFSET(0), .CONV_WAIT(CONV_WAIT)) u_a (
    .clk(clk), .rst_n(rst_a_n), .enable(en_a), .spi(spi_a), .temp(temp_a), .temp_ch(ch_a),
    .open_tc(open_a), .temp_valid(valid_a), .dbg_state_o(dbg_a));

  thermo_spi_scanner #(.CLK_DIV(CLK_DIV), .N_CH(1), .CAL_OFFSET(-20), .CONV_WAIT(CONV_WAIT)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .spi(spi_b), .temp(temp_b), .temp_ch(ch_b),
    .open_tc(open_b), .temp_valid(valid_b), .dbg_state_o(dbg_b));

  thermo_spi_scanner #(.CLK_DIV(CLK_DIV), .N_CH(1), .CAL_OFFSET(20), .CONV_WAIT(CONV_WAIT)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .spi(spi_c), .temp(temp_c), .temp_ch(ch_c),
    .open_tc(open_c), .temp_valid(valid_c), .dbg_state_o(dbg_c));

  // ---------------- sensor models ----------------
  logic [15:0] frm_a [3];
  logic [15:0] frm_b, frm_c;
  logic [15:0] sr_a = '0, sr_b = '0, sr_c = '0;
  logic [2:0]  cs_prev_a = 3'b111;
  logic        cs_prev_b = 1'b1, cs_prev_c = 1'b1;

  always @(spi_a.cs_n or negedge spi_a.sck) begin
    if (spi_a.cs_n != cs_prev_a) begin
      for (int i = 0; i < 3; i++) if (!spi_a.cs_n[i]) sr_a = frm_a[i];
      cs_prev_a = spi_a.cs_n;
    end else if (!spi_a.sck) begin
      sr_a = {sr_a[14:0], 1'b0};
    end
  end
  assign spi_a.so = sr_a[15];

  always @(spi_b.cs_n or negedge spi_b.sck) begin
    if (spi_b.cs_n[0] != cs_prev_b) begin
      if (!spi_b.cs_n[0]) sr_b = frm_b;
      cs_prev_b = spi_b.cs_n[0];
    end else if (!spi_b.sck) begin
      sr_b = {sr_b[14:0], 1'b0};
    end
  end
  assign spi_b.so = sr_b[15];

  always @(spi_c.cs_n or negedge spi_c.sck) begin
    if (spi_c.cs_n[0] != cs_prev_c) begin
      if (!spi_c.cs_n[0]) sr_c = frm_c;
      cs_prev_c = spi_c.cs_n[0];
    end else if (!spi_c.sck) begin
      sr_c = {sr_c[14:0], 1'b0};
    end
  end
  assign spi_c.so = sr_c[15];

  // ---------------- monitors ----------------
  logic [15:0] obs_a[$], obs_b[$], obs_c[$];
  int          cyc_q_a[$];
  int          vrun_a = 0, vrun_b = 0, vrun_c = 0, vmax = 0;
  int          run0_a = 0, last_low0_a = 0;
  int          multi_a = 0, cs_low_total_a = 0;

  function automatic logic [15:0] pack(input int ch, input logic open, input logic [11:0] t);
    return {1'b0, 2'(ch), open, t};
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid_a) begin
      obs_a.push_back(pack(int'(ch_a), open_a, temp_a));
      cyc_q_a.push_back(cyc);
    end
    if (valid_b) obs_b.push_back(pack(int'(ch_b), open_b, temp_b));
    if (valid_c) obs_c.push_back(pack(int'(ch_c), open_c, temp_c));
    vrun_a = valid_a ? vrun_a + 1 : 0;
    vrun_b = valid_b ? vrun_b + 1 : 0;
    vrun_c = valid_c ? vrun_c + 1 : 0;
    if (vrun_a > vmax) vmax = vrun_a;
    if (vrun_b > vmax) vmax = vrun_b;
    if (vrun_c > vmax) vmax = vrun_c;
    if (!spi_a.cs_n[0]) run0_a++;
    else if (run0_a != 0) begin
      last_low0_a = run0_a;
      run0_a = 0;
    end
    if ($countones(~spi_a.cs_n) > 1) multi_a++;
    if (spi_a.cs_n != 3'b111) cs_low_total_a++;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  // Reference: open flag forces 0, else raw field plus offset clamped to 12 bits.
  function automatic logic [15:0] model(input int ch, input logic [15:0] f, input int off);
    int v;
    if (f[2]) return pack(ch, 1'b1, 12'd0);
    v = int'(f[14:3]) + off;
    if (v < 0) v = 0;
    if (v > 4095) v = 4095;
    return pack(ch, 1'b0, 12'(v));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int obs_size(input int d);
    return (d == 0) ? obs_a.size() : (d == 1) ? obs_b.size() : obs_c.size();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic get_obs(input int d, output logic [15:0] v, output int stb_cyc, output bit ok);
    v = '0;
    stb_cyc = 0;
    for (int t = 0; t < TIMEOUT; t++) begin
      if (obs_size(d) != 0) break;
      @(negedge clk);
      #1;
    end
    ok = (obs_size(d) != 0);
    if (ok) begin
      if (d == 0) begin
        v = obs_a.pop_front();
        stb_cyc = cyc_q_a.pop_front();
      end else if (d == 1) begin
        v = obs_b.pop_front();
      end else begin
        v = obs_c.pop_front();
      end
    end
  endtask

  task automatic expect_frame(input int d, input string tag, input int ch, input logic [15:0] f,
                              input int off, output int stb_cyc);
    logic [15:0] got;
    bit          ok;
    exp_q.push_back(model(ch, f, off));
    get_obs(d, got, stb_cyc, ok);
    check({tag, "_arrived"}, 32'(ok), 32'd1);
    if (ok) check(tag, 32'(got), 32'(exp_q.pop_front()));
    else    void'(exp_q.pop_front());
  endtask

  task automatic wait_sck_rises_a(input int n, output bit ok);
    int   seen;
    logic prev;
    seen = 0;
    prev = spi_a.sck;
    for (int t = 0; t < TIMEOUT && seen < n; t++) begin
      @(negedge clk);
      #1;
      if (spi_a.sck && !prev) seen++;
      prev = spi_a.sck;
    end
    ok = (seen == n);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          nc, c0, c1, c2, snap_cs, snap_obs;
    bit          ok;
    logic [15:0] f;

    rst_n = 1'b0; rst_a_n = 1'b0;
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
    frm_a[0] = 16'h0C80; frm_a[1] = 16'h0010; frm_a[2] = 16'h0018;
    frm_b = 16'h0050; frm_c = 16'h7FF8;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n",  32'(spi_a.cs_n), 32'h7);
    check("rst_sck",   32'(spi_a.sck), 32'h0);
    check("rst_temp",  32'(temp_a), 32'h0);
    check("rst_ch",    32'(ch_a), 32'h0);
    check("rst_open",  32'(open_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_cs_b",  32'(spi_b.cs_n), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; rst_a_n = 1'b1;

    // basic frame on channel 0
    expect_frame(0, "basic", 0, 16'h0C80, 0, c0);
    check("cs_low_len", 32'(last_low0_a), 32'(FRAME_CYC));

    // round robin 1,2,0
    frm_a[0] = 16'h0008;
    expect_frame(0, "rr_ch1", 1, 16'h0010, 0, c1);
    expect_frame(0, "rr_ch2", 2, 16'h0018, 0, c2);
    check("scan_period", 32'(c2 - c1), 32'(PERIOD));
    expect_frame(0, "rr_ch0", 0, 16'h0008, 0, c0);

    // open thermocouple
    frm_a[1] = 16'h0C84;
    expect_frame(0, "open_tc", 1, 16'h0C84, 0, c1);
    nc = 2;

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      f = 16'($urandom_range(0, 65535));
      frm_a[nc] = f;
      expect_frame(0, "rand_a", nc, f, 0, c0);
      nc = (nc + 1) % 3;
    end

    // enable drop mid-SHIFT
    f = 16'($urandom_range(0, 65535));
    frm_a[nc] = f;
    wait_sck_rises_a(4, ok);
    check("drop_reach_shift", 32'(ok), 32'd1);
    en_a = 1'b0;
    expect_frame(0, "drop_frame", nc, f, 0, c0);
    nc = (nc + 1) % 3;
    snap_cs = cs_low_total_a;
    snap_obs = obs_a.size();
    repeat (300) @(negedge clk);
    #1;
    check("parked_cs", 32'(cs_low_total_a - snap_cs), 32'd0);
    check("parked_strobes", 32'(obs_a.size() - snap_obs), 32'd0);
    f = 16'($urandom_range(0, 65535));
    frm_a[nc] = f;
    en_a = 1'b1;
    expect_frame(0, "resume", nc, f, 0, c0);
    nc = (nc + 1) % 3;

    // reset mid-SHIFT, around bit 7
    frm_a[0] = 16'($urandom_range(0, 65535));
    wait_sck_rises_a(8, ok);
    check("rst_reach_bit7", 32'(ok), 32'd1);
    snap_obs = obs_a.size();
    rst_a_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(spi_a.cs_n), 32'h7);
    check("midrst_sck", 32'(spi_a.sck), 32'h0);
    @(negedge clk);
    rst_a_n = 1'b1;
    #1;
    check("midrst_no_strobe", 32'(obs_a.size() - snap_obs), 32'd0);
    expect_frame(0, "after_rst_ch0", 0, frm_a[0], 0, c0);

    // low saturation with -20 offset, then random frames
    en_b = 1'b1;
    expect_frame(1, "sat_lo", 0, 16'h0050, -20, c0);
    for (int k = 0; k < 4; k++) begin
      f = 16'($urandom_range(0, 65535));
      frm_b = f;
      expect_frame(1, "rand_b", 0, f, -20, c0);
    end

    // high saturation with +20 offset, then random frames
    en_c = 1'b1;
    expect_frame(2, "sat_hi", 0, 16'h7FF8, 20, c0);
    for (int k = 0; k < 4; k++) begin
      f = 16'($urandom_range(0, 65535));
      frm_c = f;
      expect_frame(2, "rand_c", 0, f, 20, c0);
    end

    check("one_hot_cs", 32'(multi_a), 32'd0);
    check("valid_width", 32'(vmax), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
